// File: rtl/quadrature_encoder_simple.sv
// Quadrature (A,B) decoder: per-channel synchronizer, stability filter and x4 step counter.
// A new (A,B) state is accepted only after FILTER_CYCLES identical synchronized samples.
module quadrature_encoder_simple #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 3
) (
  input  logic               clk,
  input  logic               a,
  input  logic               b,
  input  logic               reset,
  output logic signed [31:0] counter,
  output logic               cw,
  output logic               ccw
);

  localparam int unsigned CntW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES);

  logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q, valid_q;
  logic [1:0]             sync_ab;
  logic [1:0]             samp_q, samp_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [1:0]             acc_q, acc_d;
  logic                   primed_q, primed_d;
  logic signed [31:0]     counter_q, counter_d;
  logic                   cw_q, cw_d, ccw_q, ccw_d;
  logic                   accept, step_cw, step_ccw;

  assign sync_ab = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

  // valid_q marks when the chain holds real input samples rather than reset zeros,
  // so a stale 00 can never be accepted as the first state after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      valid_q  <= '0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], a};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], b};
      valid_q  <= {valid_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_comb begin
    samp_d = samp_q;
    cnt_d  = cnt_q;
    if (valid_q[SYNC_STAGES-1]) begin
      if (sync_ab != samp_q) begin
        samp_d = sync_ab;
        cnt_d  = CntW'(1);
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    step_cw  = 1'b0;
    step_ccw = 1'b0;
    case ({acc_q, samp_q})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_cw  = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_ccw = 1'b1;
      default: ;
    endcase
  end

  // The first accepted state after reset only seeds acc_q; it is never counted.
  always_comb begin
    accept    = (cnt_q == CntMax) && (!primed_q || (samp_q != acc_q));
    acc_d     = acc_q;
    primed_d  = primed_q;
    counter_d = counter_q;
    cw_d      = 1'b0;
    ccw_d     = 1'b0;
    if (accept) begin
      acc_d    = samp_q;
      primed_d = 1'b1;
      if (primed_q && step_cw) begin
        counter_d = counter_q + 32'sd1;
        cw_d      = 1'b1;
      end else if (primed_q && step_ccw) begin
        counter_d = counter_q - 32'sd1;
        ccw_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      primed_q  <= 1'b0;
      counter_q <= '0;
      cw_q      <= 1'b0;
      ccw_q     <= 1'b0;
    end else begin
      samp_q    <= samp_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      primed_q  <= primed_d;
      counter_q <= counter_d;
      cw_q      <= cw_d;
      ccw_q     <= ccw_d;
    end
  end

  assign counter = counter_q;
  assign cw      = cw_q;
  assign ccw     = ccw_q;

endmodule

// File: tb/tb_quadrature_encoder_simple.sv
// Bench for quadrature_encoder_simple: vector table, directed corner cases and random
// stimulus checked against a sliding-window reference model.
module tb_quadrature_encoder_simple;

  localparam int S = 2;
  localparam int F = 3;

  typedef struct {
    logic        a;
    logic        b;
    int          hold;
    logic [31:0] exp_cnt;
    int          exp_cw;
    int          exp_ccw;
  } vec_t;

  logic               clk = 1'b0;
  logic               a, b, reset;
  logic signed [31:0] counter;
  logic               cw, ccw;

  int n_cmp = 0;
  int n_bad = 0;
  int cw_seen, ccw_seen;

  // Reference model state: input history since reset release, accepted state, outputs.
  logic [1:0]  hist[$];
  logic [1:0]  m_acc;
  bit          m_primed;
  logic [31:0] m_cnt;
  bit          m_cw, m_ccw;

  quadrature_encoder_simple #(
    .SYNC_STAGES  (S),
    .FILTER_CYCLES(F)
  ) dut (
    .clk    (clk),
    .a      (a),
    .b      (b),
    .reset  (reset),
    .counter(counter),
    .cw     (cw),
    .ccw    (ccw)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  // Position of an (A,B) state along the clockwise cycle 00,10,11,01.
  function automatic int phase(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_acc    = 2'b00;
    m_primed = 1'b0;
    m_cnt    = '0;
    m_cw     = 1'b0;
    m_ccw    = 1'b0;
  endtask

  // State accepted at edge t iff inputs sampled at edges t-S-F .. t-S-1 are all equal.
  task automatic model_edge();
    logic [1:0] w0;
    bit         stable;
    int         t, lo, d;
    hist.push_back({a, b});
    t     = int'(hist.size());
    lo    = t - S - F;
    m_cw  = 1'b0;
    m_ccw = 1'b0;
    if (lo >= 1) begin
      w0     = hist[lo-1];
      stable = 1'b1;
      for (int i = lo; i <= t - S - 1; i++) if (hist[i-1] != w0) stable = 1'b0;
      if (stable && (!m_primed || w0 != m_acc)) begin
        if (m_primed) begin
          d = (phase(w0) - phase(m_acc) + 4) % 4;
          if (d == 1) begin
            m_cnt = m_cnt + 32'd1;
            m_cw  = 1'b1;
          end else if (d == 3) begin
            m_cnt = m_cnt - 32'd1;
            m_ccw = 1'b1;
          end
        end
        m_acc    = w0;
        m_primed = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model", {$unsigned(counter), cw, ccw}, {m_cnt, m_cw, m_ccw});
    check("cw_ccw_exclusive", {63'd0, cw & ccw}, 64'd0);
    cw_seen  += int'(cw);
    ccw_seen += int'(ccw);
  endtask

  initial begin
    vec_t       vecs[16];
    logic [1:0] seq[16];

    seq = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00,
            2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    for (int r = 0; r < 16; r++) begin
      vecs[r].a       = seq[r][1];
      vecs[r].b       = seq[r][0];
      vecs[r].hold    = 25;
      vecs[r].exp_cnt = (r < 8) ? 32'(r + 1) : 32'(15 - r);
      vecs[r].exp_cw  = (r < 8) ? 1 : 0;
      vecs[r].exp_ccw = (r < 8) ? 0 : 1;
    end

    a = 1'b0;
    b = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_counter", {32'd0, $unsigned(counter)}, 64'd0);
    check("reset_pulses", {62'd0, cw, ccw}, 64'd0);

    #2 reset = 1'b0;
    model_reset();
    cw_seen = 0;
    ccw_seen = 0;
    repeat (20) tick();
    check("prime_counter", {32'd0, $unsigned(counter)}, 64'd0);
    check("prime_pulses", 64'(cw_seen + ccw_seen), 64'd0);

    for (int r = 0; r < 16; r++) begin
      a = vecs[r].a;
      b = vecs[r].b;
      cw_seen = 0;
      ccw_seen = 0;
      repeat (vecs[r].hold) tick();
      check($sformatf("vec%0d_counter", r), {32'd0, $unsigned(counter)},
            {32'd0, vecs[r].exp_cnt});
      check($sformatf("vec%0d_cw_pulses", r), 64'(cw_seen), 64'(vecs[r].exp_cw));
      check($sformatf("vec%0d_ccw_pulses", r), 64'(ccw_seen), 64'(vecs[r].exp_ccw));
    end

    // Two-sample glitch is filtered; a held level counts exactly six edges later.
    cw_seen = 0;
    ccw_seen = 0;
    a = 1'b1;
    repeat (2) tick();
    a = 1'b0;
    repeat (10) tick();
    check("glitch_counter", {32'd0, $unsigned(counter)}, 64'd0);
    check("glitch_pulses", 64'(cw_seen + ccw_seen), 64'd0);
    a = 1'b1;
    repeat (5) tick();
    check("latency5_counter", {32'd0, $unsigned(counter)}, 64'd0);
    tick();
    check("latency6_counter", {32'd0, $unsigned(counter)}, 64'd1);
    check("latency6_cw", {63'd0, cw}, 64'd1);
    tick();
    check("latency7_cw", {63'd0, cw}, 64'd0);
    repeat (8) tick();

    a = 1'b0;
    repeat (12) tick();
    check("back_to_00", {32'd0, $unsigned(counter)}, 64'd0);
    cw_seen = 0;
    ccw_seen = 0;
    a = 1'b1;
    b = 1'b1;
    repeat (12) tick();
    check("illegal_counter", {32'd0, $unsigned(counter)}, 64'd0);
    check("illegal_pulses", 64'(cw_seen + ccw_seen), 64'd0);
    a = 1'b0;
    repeat (12) tick();
    check("after_illegal_counter", {32'd0, $unsigned(counter)}, 64'd1);
    check("after_illegal_cw", 64'(cw_seen), 64'd1);

    // Wrap-around from a forced preload at the positive limit.
    force dut.counter_q = 32'sh7FFF_FFFF;
    #1 release dut.counter_q;
    m_cnt = 32'h7FFF_FFFF;
    b = 1'b0;
    repeat (10) tick();
    check("wrap_up", {32'd0, $unsigned(counter)}, 64'h8000_0000);
    b = 1'b1;
    repeat (10) tick();
    check("wrap_down", {32'd0, $unsigned(counter)}, 64'h7FFF_FFFF);

    // Asynchronous reset mid-transition, released with inputs at 11.
    a = 1'b1;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    check("async_reset_counter", {32'd0, $unsigned(counter)}, 64'd0);
    check("async_reset_pulses", {62'd0, cw, ccw}, 64'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    cw_seen = 0;
    ccw_seen = 0;
    repeat (20) tick();
    check("post_reset_counter", {32'd0, $unsigned(counter)}, 64'd0);
    check("post_reset_pulses", 64'(cw_seen + ccw_seen), 64'd0);
    a = 1'b0;
    repeat (10) tick();
    check("post_reset_step", {32'd0, $unsigned(counter)}, 64'd1);
    check("post_reset_cw", 64'(cw_seen), 64'd1);

    for (int k = 0; k < 300; k++) begin
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 6)) tick();
    end
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
